nec_ir_receiver: RTL
====================

# nec_ir_receiver

Receives and decodes NEC-format infrared remote-control frames from a demodulated IR receiver module (TSOP-style, active-low output) and presents the decoded address and command bytes. It is the receive-side counterpart to the `tv_b_gone` IR transmitter. It sits on the same 8 MHz clock domain in the pico-ice top and will be used for self-test loopback of `ctc_out` and for learning codes.

## Interface
Parameters:
- `CLKS_PER_TICK`, 450, clock cycles per measurement tick. At 8 MHz this gives a 56.25 µs tick, so one NEC unit is 562.5 µs, or 10 ticks.
- `FILTER_LEN`, 4, number of consecutive identical synchronized samples required before the filtered level changes.
- `IR_ACTIVE_LOW`, 1, when 1 the raw input low means mark (carrier present).

Ports:
- `clock_in`  in  1  single clock for all logic.
- `resetn_in`  in  1  asynchronous, active-low reset. Clears all state and outputs.
- `ir_in`  in  1  raw demodulated IR input. Asynchronous to the clock.
- `valid_out`  out  1  one-cycle pulse when a complete frame passes all checks.
- `repeat_out`  out  1  one-cycle pulse when a valid NEC repeat code is received.
- `error_out`  out  1  one-cycle pulse on a timing violation, timeout, or inverse-byte mismatch.
- `busy_out`  out  1  high whenever the FSM is not IDLE.
- `address_out`  out  8  last valid address. Updated only together with `valid_out`.
- `command_out`  out  8  last valid command. Updated only together with `valid_out`.

## Operation
- **Input conditioning**
  - `ir_in` passes through a 2-flop synchronizer and is then normalized by `IR_ACTIVE_LOW`, giving mark=1.
  - The glitch filter changes its output only after `FILTER_LEN` consecutive equal samples.
- **Tick counter**
  - The prescaler counts 0..`CLKS_PER_TICK`-1.
  - The 8-bit duration counter increments on each prescaler wrap and saturates at 255.
  - Both counters clear on every filtered edge, so each segment is measured in ticks with a quantization of -1 tick.
- **Classification** (inclusive windows, in ticks):
  - LEAD_M: 144–176
  - LEAD_S: 72–88
  - REP_S: 36–44
  - UNIT: 7–13
  - ONE_S: 25–35
- **FSM states**: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, REP_MARK.
- **Transitions** (classification is taken on the edge that ends a segment):
  - IDLE → LEAD_MARK on a filtered mark-start edge only. A stuck mark level never retriggers.
  - LEAD_MARK, mark end with LEAD_M → LEAD_SPACE.
  - LEAD_SPACE, space end:
    - with LEAD_S → BIT_MARK; the bit counter clears.
    - with REP_S → REP_MARK.
  - BIT_MARK, mark end with UNIT → BIT_SPACE.
  - BIT_SPACE, space end:
    - UNIT shifts in 0; ONE_S shifts in 1. Bits arrive LSB first into a 32-bit shift register.
    - If this was bit 32 → STOP_MARK, else → BIT_MARK.
  - STOP_MARK, mark end with UNIT:
    - If byte1 == ~byte0 and byte3 == ~byte2: load `address_out`=byte0 and `command_out`=byte2, pulse `valid_out`, → IDLE.
    - Otherwise pulse `error_out` and → IDLE.
  - REP_MARK, mark end with UNIT → pulse `repeat_out`, → IDLE. `address_out` and `command_out` are unchanged.
  - Any out-of-window duration in a non-IDLE state → pulse `error_out`, → IDLE.
  - Duration counter reaching 255 in any non-IDLE state (timeout, about 14.3 ms) → pulse `error_out`, → IDLE.
- **Pulse exclusivity**: `valid_out`, `repeat_out` and `error_out` are mutually exclusive; at most one pulses per cycle.

## Timing
- **Reset values**: all outputs 0, FSM in IDLE, filter output = space. Reset asserted mid-frame aborts the frame with no pulse.
- **Latency**: from a raw `ir_in` edge to the FSM seeing the filtered edge is 2 (synchronizer) + `FILTER_LEN` cycles.
- **Registered outputs**: `valid_out`, `repeat_out` and `error_out` pulse in the cycle after the FSM sees the terminating edge, i.e. 3 + `FILTER_LEN` cycles after the raw edge. `address_out` and `command_out` change in that same cycle.
- **Timeout vs. edge**: if saturation and a filtered edge coincide, the edge is classified against a duration of 255, which is out of window, so `error_out` pulses exactly once.
- **Back-to-back frames**: a new lead mark may begin in the cycle after the return to IDLE.

## Structure
- **Package `ir_nec_pkg`**: FSM state enum, the tick-window min/max localparams, and the 8-bit duration type.
- **Sub-module `ir_input_filter`**: synchronizer, polarity normalization and glitch filter. Outputs are the filtered level plus a one-cycle edge strobe.
- **`nec_ir_receiver` itself**: prescaler, duration counter, FSM and shift register.

## Test plan
- **Valid frame**: frame bytes 0x04, 0xFB, 0x08, 0xF7 with nominal timing → one `valid_out` pulse; `address_out`=0x04, `command_out`=0x08; `error_out` never asserts.
- **Repeat code**: after the previous frame, send a 9 ms mark, 2.25 ms space, 562.5 µs mark → one `repeat_out` pulse; outputs hold 0x04 / 0x08.
- **Inverse mismatch**: bytes 0x04, 0xFB, 0x08, 0xF6 → one `error_out` pulse; no `valid_out`; outputs unchanged.
- **Glitch rejection**: a 2-cycle and a (`FILTER_LEN`-1)-cycle spurious pulse, both in IDLE and mid-frame → no state change; the frame still decodes.
- **Truncated frame and timing edges**:
  - Line stops after 16 bits → `error_out` after 255 ticks; `busy_out` falls.
  - Lead mark of 143 ticks → error; lead mark of 176 ticks → accepted.
- **Reset mid-frame**: assert `resetn_in` low during bit 10 → all outputs 0 immediately; the next full frame decodes correctly.

Source files
------------

// File: rtl/ir_nec_pkg.sv
// Shared types and tick windows for the NEC IR receiver.
// All windows are inclusive and measured in prescaler ticks.
package ir_nec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD_MARK,
        ST_LEAD_SPACE,
        ST_BIT_MARK,
        ST_BIT_SPACE,
        ST_STOP_MARK,
        ST_REP_MARK
    } nec_state_e;

    typedef logic [7:0] dur_t;

    localparam dur_t DUR_MAX    = 8'd255;

    localparam dur_t LEAD_M_MIN = 8'd144;
    localparam dur_t LEAD_M_MAX = 8'd176;
    localparam dur_t LEAD_S_MIN = 8'd72;
    localparam dur_t LEAD_S_MAX = 8'd88;
    localparam dur_t REP_S_MIN  = 8'd36;
    localparam dur_t REP_S_MAX  = 8'd44;
    localparam dur_t UNIT_MIN   = 8'd7;
    localparam dur_t UNIT_MAX   = 8'd13;
    localparam dur_t ONE_S_MIN  = 8'd25;
    localparam dur_t ONE_S_MAX  = 8'd35;

    function automatic logic in_window(dur_t d, dur_t lo, dur_t hi);
        return (d >= lo) && (d <= hi);
    endfunction

endpackage

// File: rtl/ir_input_filter.sv
// Synchronizes the raw IR line, normalizes it to mark=1 and rejects glitches
// shorter than FILTER_LEN samples. edge_out pulses for one cycle on each change.
module ir_input_filter #(
    parameter int unsigned FILTER_LEN    = 4,
    parameter bit          IR_ACTIVE_LOW = 1'b1
) (
    input  logic clock_in,
    input  logic resetn_in,
    input  logic ir_in,
    output logic level_out,
    output logic edge_out
);

    localparam int unsigned CNT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);
    // Raw level of an idle (space) line; also the synchronizer reset value.
    localparam logic IDLE_RAW = IR_ACTIVE_LOW;

    logic             sync1_q, sync2_q;
    logic             sample;
    logic             level_q, level_d;
    logic             edge_q, edge_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign sample = sync2_q ^ IDLE_RAW;

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        level_d = level_q;
        edge_d  = 1'b0;
        cnt_d   = '0;
        if (sample != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sample;
                edge_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock_in or negedge resetn_in) begin
        if (!resetn_in) begin
            sync1_q <= IDLE_RAW;
            sync2_q <= IDLE_RAW;
            level_q <= 1'b0;
            edge_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= ir_in;
            sync2_q <= sync1_q;
            level_q <= level_d;
            edge_q  <= edge_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_out = level_q;
    assign edge_out  = edge_q;

endmodule

// File: rtl/nec_ir_receiver.sv
// NEC IR frame decoder: measures filtered segment lengths in ticks and walks
// the lead / 32-bit / stop sequence, reporting frames, repeats and errors.
module nec_ir_receiver
    import ir_nec_pkg::*;
#(
    parameter int unsigned CLKS_PER_TICK = 450,
    parameter int unsigned FILTER_LEN    = 4,
    parameter bit          IR_ACTIVE_LOW = 1'b1
) (
    input  logic       clock_in,
    input  logic       resetn_in,
    input  logic       ir_in,
    output logic       valid_out,
    output logic       repeat_out,
    output logic       error_out,
    output logic       busy_out,
    output logic [7:0] address_out,
    output logic [7:0] command_out
);

    localparam int unsigned PRE_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLKS_PER_TICK - 1);

    logic             f_level, f_edge;
    logic [PRE_W-1:0] pre_q, pre_d;
    dur_t             dur_q, dur_d;
    nec_state_e       st_q, st_d;
    logic [31:0]      sr_q, sr_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic             valid_q, valid_d;
    logic             repeat_q, repeat_d;
    logic             error_q, error_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       cmd_q, cmd_d;

    ir_input_filter #(
        .FILTER_LEN   (FILTER_LEN),
        .IR_ACTIVE_LOW(IR_ACTIVE_LOW)
    ) u_filter (
        .clock_in (clock_in),
        .resetn_in(resetn_in),
        .ir_in    (ir_in),
        .level_out(f_level),
        .edge_out (f_edge)
    );

    // Each filtered edge restarts the measurement of the next segment.
    always_comb begin
        pre_d = pre_q + 1'b1;
        dur_d = dur_q;
        if (f_edge) begin
            pre_d = '0;
            dur_d = '0;
        end else if (pre_q == PRE_LAST) begin
            pre_d = '0;
            if (dur_q != DUR_MAX) dur_d = dur_q + 1'b1;
        end
    end

    always_comb begin
        st_d      = st_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        valid_d   = 1'b0;
        repeat_d  = 1'b0;
        error_d   = 1'b0;
        addr_d    = addr_q;
        cmd_d     = cmd_q;

        if (st_q == ST_IDLE) begin
            if (f_edge && f_level) st_d = ST_LEAD_MARK;
        end else if (dur_q == DUR_MAX) begin
            // Also covers an edge landing on saturation: one error either way.
            st_d    = ST_IDLE;
            error_d = 1'b1;
        end else if (f_edge) begin
            // Any segment that matches no window below aborts the frame.
            st_d    = ST_IDLE;
            error_d = 1'b1;
            unique case (st_q)
                ST_LEAD_MARK: begin
                    if (in_window(dur_q, LEAD_M_MIN, LEAD_M_MAX)) begin
                        st_d    = ST_LEAD_SPACE;
                        error_d = 1'b0;
                    end
                end
                ST_LEAD_SPACE: begin
                    if (in_window(dur_q, LEAD_S_MIN, LEAD_S_MAX)) begin
                        st_d      = ST_BIT_MARK;
                        bit_cnt_d = '0;
                        error_d   = 1'b0;
                    end else if (in_window(dur_q, REP_S_MIN, REP_S_MAX)) begin
                        st_d    = ST_REP_MARK;
                        error_d = 1'b0;
                    end
                end
                ST_BIT_MARK: begin
                    if (in_window(dur_q, UNIT_MIN, UNIT_MAX)) begin
                        st_d    = ST_BIT_SPACE;
                        error_d = 1'b0;
                    end
                end
                ST_BIT_SPACE: begin
                    if (in_window(dur_q, UNIT_MIN, UNIT_MAX) ||
                        in_window(dur_q, ONE_S_MIN, ONE_S_MAX)) begin
                        sr_d      = {in_window(dur_q, ONE_S_MIN, ONE_S_MAX), sr_q[31:1]};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        st_d      = (bit_cnt_q == 5'd31) ? ST_STOP_MARK : ST_BIT_MARK;
                        error_d   = 1'b0;
                    end
                end
                ST_STOP_MARK: begin
                    if (in_window(dur_q, UNIT_MIN, UNIT_MAX) &&
                        (sr_q[15:8] == ~sr_q[7:0]) && (sr_q[31:24] == ~sr_q[23:16])) begin
                        valid_d = 1'b1;
                        error_d = 1'b0;
                        addr_d  = sr_q[7:0];
                        cmd_d   = sr_q[23:16];
                    end
                end
                ST_REP_MARK: begin
                    if (in_window(dur_q, UNIT_MIN, UNIT_MAX)) begin
                        repeat_d = 1'b1;
                        error_d  = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock_in or negedge resetn_in) begin
        if (!resetn_in) begin
            pre_q     <= '0;
            dur_q     <= '0;
            st_q      <= ST_IDLE;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            valid_q   <= 1'b0;
            repeat_q  <= 1'b0;
            error_q   <= 1'b0;
            addr_q    <= '0;
            cmd_q     <= '0;
        end else begin
            pre_q     <= pre_d;
            dur_q     <= dur_d;
            st_q      <= st_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            valid_q   <= valid_d;
            repeat_q  <= repeat_d;
            error_q   <= error_d;
            addr_q    <= addr_d;
            cmd_q     <= cmd_d;
        end
    end

    assign valid_out   = valid_q;
    assign repeat_out  = repeat_q;
    assign error_out   = error_q;
    assign busy_out    = (st_q != ST_IDLE);
    assign address_out = addr_q;
    assign command_out = cmd_q;

endmodule
